// File: rtl/spi_slave_mem_if.sv
// rtl/spi_slave_mem_if.sv - SPI bus signals shared by master and slave
// MISO is a net so the slave can release it to high-Z while deselected.
interface spi_slave_mem_if;
  logic CS;
  logic MOSI;
  wire  MISO;

  modport slave  (input CS, input MOSI, output MISO);
  modport master (output CS, output MOSI, input MISO);
endinterface

// File: rtl/spi_slave_mem.sv
// rtl/spi_slave_mem.sv - SPI mode-0 slave with a 2^ADDR_WIDTH x DATA_WIDTH register memory
// Protocol: command byte, start address byte, then auto-incrementing data bytes.
module spi_slave_mem #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] WRITE_CMD  = 'h02,
  parameter logic [DATA_WIDTH-1:0] READ_CMD   = 'h03
) (
  input  logic           SCLK,
  input  logic           RST_N,
  spi_slave_mem_if.slave spi
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_CMD  = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_IGN  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  rd_flag_q, rd_flag_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  byte_done;
  logic [DATA_WIDTH-1:0] shift_in;
  logic                  wr_en;
  logic                  miso_bit;

  assign byte_done = (cnt_q == LAST_BIT);
  assign shift_in  = {shift_q[DATA_WIDTH-2:0], spi.MOSI};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    rd_flag_d = rd_flag_q;
    addr_d    = addr_q;
    wr_en     = 1'b0;
    case (state_q)
      ST_CMD: begin
        cnt_d   = cnt_q + CNT_W'(1);
        shift_d = shift_in;
        if (byte_done) begin
          shift_d = '0;
          if (shift_in == WRITE_CMD) begin
            state_d   = ST_ADDR;
            rd_flag_d = 1'b0;
          end else if (shift_in == READ_CMD) begin
            state_d   = ST_ADDR;
            rd_flag_d = 1'b1;
          end else begin
            state_d = ST_IGN;
          end
        end
      end
      ST_ADDR: begin
        cnt_d  = cnt_q + CNT_W'(1);
        addr_d = {addr_q[ADDR_WIDTH-2:0], spi.MOSI};
        if (byte_done) state_d = rd_flag_q ? ST_RD : ST_WR;
      end
      ST_WR: begin
        cnt_d   = cnt_q + CNT_W'(1);
        shift_d = shift_in;
        if (byte_done) begin
          wr_en   = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          shift_d = '0;
        end
      end
      ST_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The falling edge before this rising edge already loaded mem[addr_q].
        if (cnt_q == '0) addr_d = addr_q + ADDR_WIDTH'(1);
      end
      ST_IGN: begin
        state_d = ST_IGN;
      end
      default: state_d = ST_CMD;
    endcase
  end

  // CS high acts as an asynchronous reset of the framing logic only.
  always_ff @(posedge SCLK or negedge RST_N or posedge spi.CS) begin
    if (!RST_N || spi.CS) begin
      state_q   <= ST_CMD;
      cnt_q     <= '0;
      shift_q   <= '0;
      rd_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      rd_flag_q <= rd_flag_d;
    end
  end

  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      addr_q <= addr_d;
      if (wr_en) mem_q[addr_q] <= shift_in;
    end
  end

  always_comb begin
    out_d = {out_q[DATA_WIDTH-2:0], 1'b0};
    if (state_q == ST_RD && cnt_q == '0) out_d = mem_q[addr_q];
  end

  always_ff @(negedge SCLK or negedge RST_N or posedge spi.CS) begin
    if (!RST_N || spi.CS) out_q <= '0;
    else                  out_q <= out_d;
  end

  assign miso_bit = (state_q == ST_RD) ? out_q[DATA_WIDTH-1] : 1'b0;
  assign spi.MISO = spi.CS ? 1'bz : miso_bit;

endmodule

// File: tb/tb_spi_slave_mem.sv
// tb/tb_spi_slave_mem.sv - directed self-checking bench for spi_slave_mem
// Bus actions start just after a falling edge; MISO is read before the next rising edge.
module tb_spi_slave_mem;

  logic SCLK = 1'b0;
  logic RST_N;
  spi_slave_mem_if ifc();

  spi_slave_mem #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .WRITE_CMD (8'h02),
    .READ_CMD  (8'h03)
  ) dut (
    .SCLK (SCLK),
    .RST_N(RST_N),
    .spi  (ifc.slave)
  );

  always #5 SCLK = ~SCLK;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] rx;
  logic [7:0] acc;
  int         bad;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rxo);
    for (int i = 7; i >= 0; i--) begin
      rxo[i]   = ifc.MISO;
      ifc.MOSI = tx[i];
      @(negedge SCLK);
      #1;
    end
  endtask

  task automatic cs_on();
    @(negedge SCLK);
    #1;
    ifc.CS = 1'b0;
  endtask

  task automatic cs_off();
    ifc.CS   = 1'b1;
    ifc.MOSI = 1'b0;
    repeat (2) @(negedge SCLK);
    #1;
  endtask

  task automatic wr1(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    cs_on();
    xfer(8'h02, dummy);
    xfer(a, dummy);
    xfer(d, dummy);
    cs_off();
  endtask

  task automatic rd1(input logic [7:0] a, output logic [7:0] d);
    logic [7:0] dummy;
    cs_on();
    xfer(8'h03, dummy);
    xfer(a, dummy);
    xfer(8'h00, d);
    cs_off();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N    = 1'b0;
    ifc.CS   = 1'b1;
    ifc.MOSI = 1'b0;
    #12;
    n_cmp++;
    assert (ifc.MISO === 1'bz) else begin
      n_err++;
      $error("FAIL reset_miso_hiz: observed %b expected z", ifc.MISO);
    end
    ifc.CS = 1'b0;
    #2;
    check("reset_miso_low", {15'b0, ifc.MISO}, 16'h0);
    ifc.CS = 1'b1;
    #3;
    RST_N = 1'b1;
    repeat (2) @(negedge SCLK);
    #1;

    // Single write then read back
    wr1(8'h00, 8'hAA);
    cs_on();
    xfer(8'h03, rx);
    check("rd_cmd_miso", {8'h0, rx}, 16'h00);
    xfer(8'h00, rx);
    check("rd_addr_miso", {8'h0, rx}, 16'h00);
    xfer(8'h00, rx);
    check("single_rd", {8'h0, rx}, 16'hAA);
    cs_off();

    // Unknown command is ignored and keeps MISO low
    cs_on();
    acc = 8'h00;
    xfer(8'h05, rx); acc = acc | rx;
    xfer(8'h10, rx); acc = acc | rx;
    xfer(8'h77, rx); acc = acc | rx;
    xfer(8'hFF, rx); acc = acc | rx;
    check("ignore_miso", {8'h0, acc}, 16'h00);
    cs_off();
    rd1(8'h10, rx);
    check("ignore_no_write", {8'h0, rx}, 16'h00);

    // Abort after 4 data bits, then a clean write must decode
    cs_on();
    xfer(8'h02, rx);
    xfer(8'h20, rx);
    for (int i = 0; i < 4; i++) begin
      ifc.MOSI = 1'b1;
      @(negedge SCLK);
      #1;
    end
    cs_off();
    wr1(8'h21, 8'h3C);
    cs_on();
    xfer(8'h03, rx);
    xfer(8'h20, rx);
    xfer(8'h00, rx);
    check("abort_unchanged", {8'h0, rx}, 16'h00);
    xfer(8'h00, rx);
    check("post_abort_write", {8'h0, rx}, 16'h3C);
    cs_off();

    // Full-memory burst write and gap-free burst read
    cs_on();
    xfer(8'h02, rx);
    xfer(8'h00, rx);
    repeat (256) xfer(8'hAA, rx);
    cs_off();
    cs_on();
    xfer(8'h03, rx);
    xfer(8'h00, rx);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      xfer(8'h00, rx);
      if (rx !== 8'hAA) bad++;
    end
    check("burst_bad_bytes", 16'(bad), 16'd0);
    cs_off();

    // Address wrap from 0xFF to 0x00
    cs_on();
    xfer(8'h02, rx);
    xfer(8'hFF, rx);
    xfer(8'h11, rx);
    xfer(8'h22, rx);
    cs_off();
    cs_on();
    xfer(8'h03, rx);
    xfer(8'hFF, rx);
    xfer(8'h00, rx);
    check("wrap_rd_ff", {8'h0, rx}, 16'h11);
    xfer(8'h00, rx);
    check("wrap_rd_stream_00", {8'h0, rx}, 16'h22);
    xfer(8'h00, rx);
    check("wrap_rd_stream_01", {8'h0, rx}, 16'hAA);
    cs_off();
    rd1(8'h00, rx);
    check("wrap_rd_00", {8'h0, rx}, 16'h22);

    // Reset mid-transaction clears memory
    wr1(8'h03, 8'h5A);
    rd1(8'h03, rx);
    check("pre_reset_rd", {8'h0, rx}, 16'h5A);
    cs_on();
    xfer(8'h02, rx);
    for (int i = 0; i < 4; i++) begin
      ifc.MOSI = 1'b1;
      @(negedge SCLK);
      #1;
    end
    RST_N = 1'b0;
    #2;
    check("reset_cs_low_miso", {15'b0, ifc.MISO}, 16'h0);
    RST_N = 1'b1;
    ifc.CS = 1'b1;
    #1;
    n_cmp++;
    assert (ifc.MISO === 1'bz) else begin
      n_err++;
      $error("FAIL cs_high_hiz: observed %b expected z", ifc.MISO);
    end
    cs_off();
    rd1(8'h03, rx);
    check("post_reset_rd_03", {8'h0, rx}, 16'h00);
    rd1(8'hFF, rx);
    check("post_reset_rd_ff", {8'h0, rx}, 16'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
